instr_fetch_queue: RTL
======================

# instr_fetch_queue

Fetch stage that sits directly upstream of the operand-read (DMEM) stage of the pipeline. It drives the instruction-memory address and reads each decoded instruction (op, src0, src1, dst) combinationally. It buffers fetched instructions in a small FIFO and presents them to the operand-read stage over a valid/ready handshake. This decouples fetch from the multi-cycle multiplier stall (`out_ready` low while the ALU is busy) and supports redirect/flush.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `PC_W`, 5: program counter width; PC wraps modulo 2^PC_W.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset; sampled on `posedge clk`, `rst==0` resets.
- `fetch_en`  in  1  fetch allowed this cycle.
- `flush`  in  1  discard all buffered instructions and redirect PC.
- `flush_pc`  in  PC_W  new PC when `flush`=1.
- `imem_address`  out  PC_W  = current PC (combinational from PC register).
- `imem_op`  in  1  instruction op (0 add, 1 mul) at `imem_address`.
- `imem_src0`, `imem_src1`, `imem_dst`  in  5 each  register fields at `imem_address`.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer accepts head this cycle.
- `out_op`  out  1; `out_src0`, `out_src1`, `out_dst`  out  5 each; `out_pc`  out  PC_W  head entry fields.
- `level`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Entry = {op, src0, src1, dst, pc}, 16+PC_W bits; circular buffer with rd/wr pointers and a count.
- pop = `out_valid && out_ready`.
- push = `fetch_en && !flush && (count<DEPTH || pop)`. When full, push is allowed only together with a pop.
- On push: write {imem fields, PC} at wr pointer; PC <= PC+1 mod 2^PC_W (31→0 for PC_W=5).
- No push: PC holds.
- count' = count + push − pop. `out_valid` = (count≠0). Head fields are driven from the rd-pointer entry; they are don't-care when `out_valid`=0 and the bench must not check them then.
- Flush (highest priority after reset):
  - count<=0, pointers<=0, PC<=`flush_pc`.
  - Any same-cycle pop is ignored for state purposes, though the consumer may still sample the head that cycle.
  - No push occurs.
- `out_*` fields are stable while `out_valid && !out_ready` (no flush).
- Reset (`rst`==0 at posedge), overriding all else: PC=0, count=0, pointers=0, `out_valid`=0, `level`=0. Mid-operation reset discards all contents. Reset wins over `flush`.

## Timing
- Fetch-to-output latency 1 cycle: an instruction pushed at edge N is visible (`out_valid`=1) after edge N if the FIFO was empty.
- Throughput 1 instruction/cycle when `out_ready`=1 continuously. The full FIFO sustains push+pop in the same cycle.
- First cycle after reset release: `imem_address`=0; the entry for PC 0 appears after the following edge.
- After flush at edge N: `out_valid`=0 and `imem_address`=`flush_pc` during cycle N+1; the `flush_pc` instruction is valid after edge N+1.
- `imem_address` depends only on the PC register; there is no combinational path from `out_ready` to `imem_address`.
- `out_valid` and `level` are registered-state derived; there is no combinational path from inputs.

## Test plan
- Reset then streaming:
  - Stimulus: `rst`=0 two cycles, then `rst`=1, `fetch_en`=1, `out_ready`=1; imem returns field `dst`=PC.
  - Required: `out_valid` rises one cycle after release; `out_pc`/`out_dst` = 0,1,2,… one per cycle; `level` stays 1.
- Back-pressure fill:
  - Stimulus: `out_ready`=0 for 6 cycles.
  - Required: `level` goes 1,2,3,4 then holds 4; PC stops at 4; head stays `out_pc`=0.
  - Then `out_ready`=1: outputs 0,1,2,3,4,… with no gaps or duplicates.
- Full with simultaneous push/pop:
  - Stimulus: at `level`=4, hold `out_ready`=1.
  - Required: `level` stays 4 when the consumer pops every cycle; PC advances by 1 each cycle.
- Wrap-around:
  - Stimulus: run 40 instructions.
  - Required: `out_pc` sequence …,30,31,0,1,…; no stall at the wrap.
- Flush:
  - Stimulus: FIFO holding 3 entries; assert `flush`=1, `flush_pc`=17 for one cycle.
  - Required: next cycle `out_valid`=0, `level`=0, `imem_address`=17; following cycle `out_pc`=17. Old entries never reappear.
- Reset mid-operation and flush/reset collision:
  - Stimulus: `rst`=0 with `flush`=1, `flush_pc`=9, FIFO at `level`=3.
  - Required: after the edge `level`=0, `out_valid`=0, `imem_address`=0, not 9.
  - Also `fetch_en`=0 for 3 cycles: PC and `level` hold.

Source files
------------

// File: rtl/instr_fetch_queue_if.sv
// Output stream from the fetch queue to the operand-read stage.
// The master side presents the head instruction; the slave side accepts it with out_ready.
interface instr_fetch_queue_if #(
  parameter int PC_W = 5
);
  logic            out_valid;
  logic            out_ready;
  logic            out_op;
  logic [4:0]      out_src0;
  logic [4:0]      out_src1;
  logic [4:0]      out_dst;
  logic [PC_W-1:0] out_pc;

  modport master (
    output out_valid, out_op, out_src0, out_src1, out_dst, out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_op, out_src0, out_src1, out_dst, out_pc,
    output out_ready
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: drives the imem address from the PC and buffers fetched
// instructions in a small circular FIFO with a valid/ready output and flush/redirect.
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en,
  input  logic                   flush,
  input  logic [PC_W-1:0]        flush_pc,
  output logic [PC_W-1:0]        imem_address,
  input  logic                   imem_op,
  input  logic [4:0]             imem_src0,
  input  logic [4:0]             imem_src1,
  input  logic [4:0]             imem_dst,
  output logic [$clog2(DEPTH):0] level,
  instr_fetch_queue_if.master    deq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 16 + PC_W;

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [PC_W-1:0] pc_reg;
  logic            push;
  logic            pop;
  logic [EW-1:0]   head;

  assign pop  = deq.out_valid && deq.out_ready;
  // A full queue can still accept a new instruction when the head leaves this cycle.
  assign push = fetch_en && !flush && ((count_reg != CW'(DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg     <= '0;
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else if (flush) begin
      pc_reg     <= flush_pc;
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
        pc_reg     <= pc_reg + PC_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: count_reg alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wr_ptr_reg] <= {imem_op, imem_src0, imem_src1, imem_dst, pc_reg};
    end
  end

  assign head          = mem[rd_ptr_reg];
  assign imem_address  = pc_reg;
  assign level         = count_reg;
  assign deq.out_valid = (count_reg != '0);
  assign deq.out_op    = head[EW-1];
  assign deq.out_src0  = head[EW-2 -: 5];
  assign deq.out_src1  = head[EW-7 -: 5];
  assign deq.out_dst   = head[EW-12 -: 5];
  assign deq.out_pc    = head[PC_W-1:0];
endmodule
